// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame receiver: FSM state encoding,
// sync-byte constants and the error codes reported on err_code_o.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC2,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_HOLD
    } rx_state_e;

    localparam logic [7:0] SYNC_B0 = 8'hAA;
    localparam logic [7:0] SYNC_B1 = 8'h55;

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 storage, synchronous write, asynchronous read.
// Ports: clk, wr_en_i/wr_addr_i/wr_data_i write side, rd_addr_i/rd_data_o read.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Addresses past DEPTH (non power-of-two depth) read as zero.
    always_comb begin
        rd_data_o = 8'h00;
        if (32'(rd_addr_i) < DEPTH) begin
            rd_data_o = mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser: AA 55 CMD LEN payload CSUM, holds good frames until acked.
// Ports: clk, rst_n, rx_data_i/rx_int_i byte stream in; frame_valid_o,
// cmd_o, len_o, rd_addr_i/rd_data_o held frame; frame_ack_i release;
// err_o/err_code_o error pulse and last code; overrun_o dropped byte.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int  MAX_LEN        = 16,
    parameter int  TIMEOUT_CYCLES = 500_000,
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_int_i,
    output logic          frame_valid_o,
    input  logic          frame_ack_i,
    output logic [7:0]    cmd_o,
    output logic [7:0]    len_o,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          err_o,
    output logic [1:0]    err_code_o,
    output logic          overrun_o
);

    localparam logic [8:0] MAX_LEN_B = 9'(MAX_LEN);

    rx_state_e  state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic [1:0] code_q, code_d;
    logic       ovr_q, ovr_d;
    logic       wr_en;
    logic       len_ok;
    logic       last_byte;
    logic       timeout_hit;

    assign len_ok    = {1'b0, rx_data_i} <= MAX_LEN_B;
    assign last_byte = cnt_q == (len_q - 8'd1);

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW =
        (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_active;

    // Runs only while a frame is partially received.
    assign to_active = state_q inside
        {ST_SYNC2, ST_CMD, ST_LEN, ST_PAYLOAD, ST_CSUM};
    assign timeout_hit = to_active && !rx_int_i && (to_cnt_q == TO_MAX);

    always_comb begin
        to_cnt_d = '0;
        if (to_active && !rx_int_i && !timeout_hit) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout_hit = 1'b0;
`endif

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= 8'h00;
            len_q   <= 8'h00;
            sum_q   <= 8'h00;
            cnt_q   <= 8'h00;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_int_i && rx_data_i == SYNC_B0) begin
                    state_d = ST_SYNC2;
                end
            end
            ST_SYNC2: begin
                if (rx_int_i) begin
                    if (rx_data_i == SYNC_B1) begin
                        state_d = ST_CMD;
                    end else if (rx_data_i != SYNC_B0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CMD: begin
                if (rx_int_i) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (rx_int_i) begin
                    if (rx_data_i == 8'h00) state_d = ST_CSUM;
                    else if (len_ok)        state_d = ST_PAYLOAD;
                    else                    state_d = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (rx_int_i && last_byte) state_d = ST_CSUM;
            end
            ST_CSUM: begin
                if (rx_int_i) begin
                    state_d = (rx_data_i == sum_q) ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (frame_ack_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout_hit) state_d = ST_IDLE;
    end

    // Datapath and flag updates.
    always_comb begin
        cmd_d  = cmd_q;
        len_d  = len_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;
        code_d = code_q;
        ovr_d  = 1'b0;
        wr_en  = 1'b0;
        unique case (state_q)
            ST_CMD: begin
                if (rx_int_i) begin
                    cmd_d = rx_data_i;
                    sum_d = rx_data_i;
                end
            end
            ST_LEN: begin
                if (rx_int_i) begin
                    len_d = rx_data_i;
                    sum_d = sum_q + rx_data_i;
                    cnt_d = 8'h00;
                    if (!len_ok) begin
                        err_d  = 1'b1;
                        code_d = ERR_LEN;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_int_i) begin
                    wr_en = 1'b1;
                    sum_d = sum_q + rx_data_i;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CSUM: begin
                if (rx_int_i && rx_data_i != sum_q) begin
                    err_d  = 1'b1;
                    code_d = ERR_CSUM;
                end
            end
            ST_HOLD: begin
                if (rx_int_i) ovr_d = 1'b1;
            end
            default: begin
            end
        endcase
        if (timeout_hit) begin
            err_d  = 1'b1;
            code_d = ERR_TIMEOUT;
        end
    end

    assign frame_valid_o = state_q == ST_HOLD;
    assign cmd_o         = cmd_q;
    assign len_o         = len_q;
    assign err_o         = err_q;
    assign err_code_o    = code_q;
    assign overrun_o     = ovr_q;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (cnt_q[AW-1:0]),
        .wr_data_i (rx_data_i),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o)
    );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed plus randomized bench for uart_frame_rx against a frame-level
// model built from the protocol rules (sync, CMD, LEN, payload, sum).
module tb_uart_frame_rx;

    localparam int MAX_LEN = 16;
    localparam int TO      = 100;
    localparam int AW      = 4;

    typedef logic [7:0] byte_q_t [$];

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_int;
    logic          frame_valid;
    logic          frame_ack;
    logic [7:0]    cmd;
    logic [7:0]    len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          err;
    logic [1:0]    err_code;
    logic          overrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_frame_rx #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data_i     (rx_data),
        .rx_int_i      (rx_int),
        .frame_valid_o (frame_valid),
        .frame_ack_i   (frame_ack),
        .cmd_o         (cmd),
        .len_o         (len),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .err_o         (err),
        .err_code_o    (err_code),
        .overrun_o     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One strobe; returns on the falling edge after the capturing edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_int  = 1'b1;
        @(negedge clk);
        rx_int  = 1'b0;
    endtask

    task automatic send_q(input byte_q_t q);
        foreach (q[i]) send(q[i]);
    endtask

    // Reference frame builder: checksum is the mod-256 sum of CMD, LEN
    // and payload; a bad frame gets a guaranteed-different checksum.
    function automatic byte_q_t mk_frame(input logic [7:0] c,
                                         input int l,
                                         input logic [7:0] pl [MAX_LEN],
                                         input bit good);
        byte_q_t q;
        int s;
        s = c + l;
        q.push_back(8'hAA);
        q.push_back(8'h55);
        q.push_back(c);
        q.push_back(8'(l));
        for (int i = 0; i < l; i++) begin
            q.push_back(pl[i]);
            s += pl[i];
        end
        if (!good) s += 1 + $urandom_range(0, 254);
        q.push_back(8'(s % 256));
        return q;
    endfunction

    task automatic check_frame(input logic [7:0] c, input int l,
                               input logic [7:0] pl [MAX_LEN]);
        check("valid", 32'(frame_valid), 1);
        check("cmd", 32'(cmd), 32'(c));
        check("len", 32'(len), 32'(l));
        for (int i = 0; i < l; i++) begin
            rd_addr = AW'(i);
            #1;
            check("rd_data", 32'(rd_data), 32'(pl[i]));
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("ack_valid", 32'(frame_valid), 0);
    endtask

    task automatic check_err(input string tag, input logic [1:0] code);
        check({tag, "_err"}, 32'(err), 1);
        check({tag, "_code"}, 32'(err_code), 32'(code));
        check({tag, "_valid"}, 32'(frame_valid), 0);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(err), 0);
    endtask

    initial begin
        logic [7:0] pl [MAX_LEN];
        logic [7:0] rc;
        byte_q_t    q;
        int         rl;
        bit         good;
        int         k;
        int         errs;

        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_int    = 1'b0;
        frame_ack = 1'b0;
        rd_addr   = '0;
        k         = 0;
        errs      = 0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_cmd", 32'(cmd), 0);
        check("rst_len", 32'(len), 0);
        check("rst_code", 32'(err_code), 0);
        rst_n = 1'b1;

        // Basic good frame.
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
        send_q('{8'hAA, 8'h55, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19});
        check_frame(8'h10, 3, pl);
        do_ack();

        // Bad checksum, then a good frame.
        send_q('{8'hAA, 8'h55, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h18});
        check_err("csum", 2'd2);
        send_q('{8'hAA, 8'h55, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19});
        check_frame(8'h10, 3, pl);
        do_ack();

        // Repeated sync byte and zero length.
        send_q('{8'hAA, 8'hAA, 8'h55, 8'h20, 8'h00, 8'h20});
        check_frame(8'h20, 0, pl);
        do_ack();

        // Length beyond MAX_LEN, then recovery.
        send_q('{8'hAA, 8'h55, 8'h20, 8'h11});
        check_err("len", 2'd1);
        pl[0] = 8'h44;
        send_q('{8'hAA, 8'h55, 8'h21, 8'h01, 8'h44, 8'h66});
        check_frame(8'h21, 1, pl);

        // Overrun while held, held data must not change.
        send(8'h77);
        check("ovr_pulse", 32'(overrun), 1);
        check("ovr_valid", 32'(frame_valid), 1);
        @(negedge clk);
        check("ovr_clear", 32'(overrun), 0);
        check_frame(8'h21, 1, pl);
        // Byte on the ack cycle is also dropped.
        @(negedge clk);
        frame_ack = 1'b1;
        rx_data   = 8'hAA;
        rx_int    = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        rx_int    = 1'b0;
        check("ack_ovr", 32'(overrun), 1);
        check("ack_ovr_valid", 32'(frame_valid), 0);

        // SYNC2 with a non-sync byte returns silently; ack in IDLE
        // and mid-frame has no effect.
        send_q('{8'hAA, 8'h13});
        check("sync_noerr", 32'(err), 0);
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        send_q('{8'hAA, 8'h55});
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        pl[0] = 8'h05; pl[1] = 8'hF0;
        send_q('{8'h30, 8'h02, 8'h05, 8'hF0, 8'h27});
        check_frame(8'h30, 2, pl);
        do_ack();

        // Randomized frames with leading junk.
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                rc = 8'($urandom_range(0, 254));
                if (rc == 8'hAA) rc = 8'h00;
                send(rc);
            end
            rc   = 8'($urandom);
            rl   = $urandom_range(0, MAX_LEN);
            good = $urandom_range(0, 3) != 0;
            for (int i = 0; i < MAX_LEN; i++) pl[i] = 8'($urandom);
            q = mk_frame(rc, rl, pl, good);
            send_q(q);
            if (good) begin
                check_frame(rc, rl, pl);
                do_ack();
            end else begin
                check_err("rnd_csum", 2'd2);
            end
        end

        // Reset during payload.
        send_q('{8'hAA, 8'h55, 8'h10, 8'h05, 8'h01, 8'h02});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd", 32'(cmd), 0);
        check("mid_rst_len", 32'(len), 0);
        check("mid_rst_valid", 32'(frame_valid), 0);
        check("mid_rst_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk) if (err) errs++;
        check("mid_rst_noerr", errs, 0);
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
        send_q('{8'hAA, 8'h55, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19});
        check_frame(8'h10, 3, pl);
        do_ack();

        // Inter-byte silence after the sync pair.
        send_q('{8'hAA, 8'h55});
`ifdef UART_FRAME_TIMEOUT_EN
        for (int i = 1; i <= 3 * TO; i++) begin
            @(negedge clk);
            if (err) begin
                k = i;
                break;
            end
        end
        check("to_latency", k, TO);
        check("to_code", 32'(err_code), 3);
        pl[0] = 8'h7F;
        send_q('{8'hAA, 8'h55, 8'h10, 8'h01, 8'h7F, 8'h90});
        check_frame(8'h10, 1, pl);
`else
        errs = 0;
        repeat (3 * TO) @(negedge clk) if (err) errs++;
        check("no_timeout", errs, 0);
        pl[0] = 8'h7F;
        send_q('{8'h10, 8'h01, 8'h7F, 8'h90});
        check_frame(8'h10, 1, pl);
`endif
        do_ack();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 500_000, inter-byte timeout in clk cycles (10 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz, shared with uart_top.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx_data_i  input  8  received byte, from uart_top rs232_rx_data_o.
REQ-006 SHALL have port rx_int_i  input  1  one-cycle byte-valid strobe, from uart_top rs232_rx_int.
REQ-007 SHALL have port frame_valid_o  output  1  complete checksum-good frame held for the consumer.
REQ-008 SHALL have port frame_ack_i  input  1  consumer releases the held frame.
REQ-009 SHALL have ports cmd_o  output  8  and len_o  output  8  with the held frame's CMD and LEN.
REQ-010 SHALL have ports rd_addr_i  input  clog2(MAX_LEN)  and rd_data_o  output  8  as a combinational payload read port.
REQ-011 SHALL have ports err_o  output  1  (one-cycle error pulse) and err_code_o  output  2  (1 bad LEN, 2 bad checksum, 3 timeout; holds last code).
REQ-012 SHALL have port overrun_o  output  1  one-cycle pulse when a byte is dropped.

Function
REQ-013 Frame format SHALL be 0xAA, 0x55, CMD, LEN, LEN payload bytes, CSUM; CSUM = 8-bit modulo-256 sum of CMD, LEN and payload.
REQ-014 States SHALL be IDLE, SYNC2, CMD, LEN, PAYLOAD, CSUM, HOLD; state changes only on cycles with rx_int_i=1, except HOLD exit and timeout.
REQ-015 IDLE: 0xAA -> SYNC2; any other byte is discarded silently.
REQ-016 SYNC2: 0x55 -> CMD; 0xAA -> stay SYNC2; other -> IDLE, no error.
REQ-017 LEN: 0 -> CSUM; 1..MAX_LEN -> PAYLOAD; >MAX_LEN -> IDLE with err_o pulse, code 1.
REQ-018 PAYLOAD: byte n written to buffer[n], n = 0..LEN-1; after byte LEN-1 -> CSUM.
REQ-019 CSUM: match -> HOLD with frame_valid_o=1 on the cycle after the CSUM strobe; mismatch -> IDLE with err_o pulse, code 2, same latency.
REQ-020 HOLD: frame_valid_o, cmd_o, len_o and buffer SHALL stay stable until frame_ack_i=1; frame_valid_o deasserts and state returns to IDLE on the next cycle.
REQ-021 Any rx_int_i while in HOLD, including the frame_ack_i cycle, SHALL drop the byte and pulse overrun_o the next cycle.
REQ-022 frame_ack_i outside HOLD SHALL be ignored.
REQ-023 rd_data_o SHALL equal buffer[rd_addr_i]; addresses >= len_o return undefined-but-stable data.

Reset
REQ-024 On rst_n=0: state IDLE; frame_valid_o, err_o and overrun_o 0; cmd_o, len_o and err_code_o 0; byte counter, running sum and timeout counter 0. The buffer is not reset.
REQ-025 Reset mid-frame SHALL abandon the frame with no err_o pulse.

Configuration
REQ-026 Macro UART_FRAME_TIMEOUT_EN defined: in SYNC2..CSUM, a counter SHALL clear on each rx_int_i and increment otherwise; on reaching TIMEOUT_CYCLES-1 it SHALL go to IDLE and pulse err_o with code 3. The counter does not run in IDLE or HOLD.
REQ-027 Macro undefined: no timeout counter is synthesised, code 3 is never produced, and a partial frame waits indefinitely.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state encoding, the SYNC_B0=0xAA and SYNC_B1=0x55 constants, and the error-code constants.
REQ-029 The payload buffer SHALL be one sub-module, uart_frame_buf: MAX_LEN x 8, synchronous write, asynchronous read.
REQ-030 Top-level wiring SHALL connect rx_data_i and rx_int_i to uart_top rx outputs in place of the loopback.

Verification
REQ-031 Bytes AA 55 10 03 01 02 03 19 -> frame_valid_o=1 one cycle after the last strobe; cmd_o=0x10, len_o=3; rd_data_o[0..2]=01 02 03.
REQ-032 Bytes AA 55 10 03 01 02 03 18 -> err_o pulse, err_code_o=2, frame_valid_o stays 0; a following good frame is accepted.
REQ-033 Bytes AA AA 55 20 00 20 -> accepted with len_o=0. Bytes AA 55 20 11 (MAX_LEN=16) -> err_code_o=1, state IDLE.
REQ-034 Good frame held; a byte arrives before frame_ack_i -> overrun_o pulse and held data unchanged; ack -> frame_valid_o=0 next cycle.
REQ-035 With UART_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=100: AA 55 then silence -> err_code_o=3 exactly 100 cycles after the 0x55 strobe. Without the macro: no error and the frame completes later.
REQ-036 rst_n pulsed low during PAYLOAD -> all outputs 0 immediately, no err_o; the next good frame parses correctly.
